serial_byte_loader: RTL and testbench

//  Serial-to-parallel front end for the 8-bit enable register (_GGREG8 family).

---
 rtl/serial_byte_loader.sv | 148 ++++++++++++++
 tb/tb_serial_byte_loader.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/serial_byte_loader.sv
// serial_byte_loader: oversampling serial frame receiver driving D and an active-low EN load strobe.
// Define SER_PARITY_EN to add an even-parity bit after the data bits.
module serial_byte_loader #(
    parameter int DIV = 4
) (
    input  logic       CK,
    input  logic       CLR,
    input  logic       SIN,
    output logic [7:0] D,
    output logic       EN,
    output logic       FERR,
    output logic       PERR,
    output logic       BUSY
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

`ifdef SER_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAITHI} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;
`endif

    state_t          state, state_n;
    logic            s1, s;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      bitn, bitn_n;
    logic [7:0]      shreg, shreg_n, d_n;
    logic            en_n, ferr_n;

`ifdef SER_PARITY_EN
    logic pbad, pbad_n, perr_n;
`else
    assign PERR = 1'b0;
`endif

    assign BUSY = (state != IDLE) && (state != WAITHI);

    always_ff @(posedge CK or negedge CLR) begin
        if (!CLR) begin
            s1    <= 1'b1;
            s     <= 1'b1;
            state <= IDLE;
            cnt   <= '0;
            bitn  <= '0;
            shreg <= '0;
            D     <= 8'h00;
            EN    <= 1'b1;
            FERR  <= 1'b0;
`ifdef SER_PARITY_EN
            pbad  <= 1'b0;
            PERR  <= 1'b0;
`endif
        end else begin
            s1    <= SIN;
            s     <= s1;
            state <= state_n;
            cnt   <= cnt_n;
            bitn  <= bitn_n;
            shreg <= shreg_n;
            D     <= d_n;
            EN    <= en_n;
            FERR  <= ferr_n;
`ifdef SER_PARITY_EN
            pbad  <= pbad_n;
            PERR  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bitn_n  = bitn;
        shreg_n = shreg;
        d_n     = D;
        en_n    = 1'b1;
        ferr_n  = 1'b0;
`ifdef SER_PARITY_EN
        pbad_n  = pbad;
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                cnt_n = cnt + CW'(1);
                if (cnt == HALF) begin
                    cnt_n   = '0;
                    bitn_n  = '0;
                    state_n = s ? IDLE : DATA;
                end
            end
            DATA: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    shreg_n = {s, shreg[7:1]};
                    bitn_n  = bitn + 3'd1;
`ifdef SER_PARITY_EN
                    if (bitn == 3'd7) state_n = PARITY;
`else
                    if (bitn == 3'd7) state_n = STOP;
`endif
                end
            end
`ifdef SER_PARITY_EN
            PARITY: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    pbad_n  = ^{shreg, s};
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                cnt_n = cnt + CW'(1);
                if (cnt == LAST) begin
                    cnt_n = '0;
                    // a low stop bit wins over a parity error and parks until the line recovers
                    if (!s) begin
                        ferr_n  = 1'b1;
                        state_n = WAITHI;
`ifdef SER_PARITY_EN
                    end else if (pbad) begin
                        perr_n  = 1'b1;
                        state_n = IDLE;
`endif
                    end else begin
                        d_n     = shreg;
                        en_n    = 1'b0;
                        state_n = IDLE;
                    end
                end
            end
            WAITHI: begin
                if (s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_byte_loader.sv
// tb_serial_byte_loader: directed frames against a cycle-indexed event model of the receiver.
// Build with SER_PARITY_EN to exercise the parity variant.
module tb_serial_byte_loader;
    localparam int DIV = 4;
`ifdef SER_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int LAT = 3 + DIV / 2 + (NB - 1) * DIV;

    logic       CK = 1'b0, CLR = 1'b0, SIN = 1'b1;
    logic [7:0] D;
    logic       EN, FERR, PERR, BUSY;

    serial_byte_loader #(.DIV(DIV)) dut (
        .CK(CK), .CLR(CLR), .SIN(SIN), .D(D), .EN(EN),
        .FERR(FERR), .PERR(PERR), .BUSY(BUSY)
    );

    always #5 CK = ~CK;

    int cyc = 0;
    always @(posedge CK) cyc <= cyc + 1;

    bit         en_ev[4096], ferr_ev[4096], perr_ev[4096], busy_ev[4096];
    logic [7:0] d_ev[4096];
    logic [7:0] model_d = 8'h00;
    int n_pass = 0, n_total = 0, en_count = 0, ferr_count = 0, last_en_cyc = -1;
    int p;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    endtask

    // kind: 0 good frame, 1 bad stop bit, 2 bad parity, 3 start glitch
    function automatic void schedule(input int t, input logic [7:0] b, input int kind);
        int e;
        e = t + LAT;
        if (kind == 3) begin
            for (int c = t + 3; c < t + 3 + DIV / 2; c++) busy_ev[c] = 1'b1;
            return;
        end
        for (int c = t + 3; c < e; c++) busy_ev[c] = 1'b1;
        if (kind == 0) begin
            en_ev[e] = 1'b1;
            d_ev[e]  = b;
        end
        if (kind == 1) ferr_ev[e] = 1'b1;
        if (kind == 2) perr_ev[e] = 1'b1;
    endfunction

    task automatic hold(input int n);
        repeat (n) @(posedge CK);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic stopb, input logic pb, input int kind);
        schedule(cyc, b, kind);
        SIN = 1'b0;
        hold(DIV);
        for (int k = 0; k < 8; k++) begin
            SIN = b[k];
            hold(DIV);
        end
`ifdef SER_PARITY_EN
        SIN = pb;
        hold(DIV);
`else
        if (pb === 1'bx) $display("note: parity bit unused");
`endif
        SIN = stopb;
        hold(DIV);
    endtask

    task automatic send_ok(input logic [7:0] b);
        send(b, 1'b1, ^b, 0);
    endtask

    always @(negedge CK) begin
        if (!CLR) begin
            model_d = 8'h00;
            check("rst_D", D, 8'h00);
            check("rst_EN", 8'(EN), 8'd1);
            check("rst_FERR", 8'(FERR), 8'd0);
            check("rst_PERR", 8'(PERR), 8'd0);
            check("rst_BUSY", 8'(BUSY), 8'd0);
        end else begin
            if (en_ev[cyc]) model_d = d_ev[cyc];
            check("D", D, model_d);
            check("EN", 8'(EN), 8'(!en_ev[cyc]));
            check("FERR", 8'(FERR), 8'(ferr_ev[cyc]));
            check("PERR", 8'(PERR), 8'(perr_ev[cyc]));
            check("BUSY", 8'(BUSY), 8'(busy_ev[cyc]));
        end
        if (!EN) begin
            en_count++;
            last_en_cyc = cyc;
        end
        if (FERR) ferr_count++;
    end

    initial begin
        hold(3);
        check("init_D", D, 8'h00);
        check("init_EN", 8'(EN), 8'd1);
        CLR = 1'b1;
        hold(4);

        p = cyc;
        send_ok(8'h42);
        hold(3);
`ifdef SER_PARITY_EN
        check("en_latency", 8'(last_en_cyc - p), 8'd45);
`else
        check("en_latency", 8'(last_en_cyc - p), 8'd41);
`endif
        check("D_42", D, 8'h42);
        check("en_count_1", 8'(en_count), 8'd1);

        send_ok(8'h42);
        send_ok(8'h99);
        hold(3);
        check("D_99", D, 8'h99);
        check("en_count_3", 8'(en_count), 8'd3);

        schedule(cyc, 8'h00, 3);
        SIN = 1'b0;
        hold(1);
        SIN = 1'b1;
        hold(10);
        check("glitch_en_count", 8'(en_count), 8'd3);

        send(8'h99, 1'b0, 1'b0, 1);
        hold(30);
        check("waithi_BUSY", 8'(BUSY), 8'd0);
        check("ferr_D", D, 8'h99);
        check("ferr_count", 8'(ferr_count), 8'd1);
        check("ferr_en_count", 8'(en_count), 8'd3);
        SIN = 1'b1;
        hold(5);

        schedule(cyc, 8'h5A, 0);
        SIN = 1'b0;
        hold(DIV);
        hold(DIV);
        SIN = 1'b1;
        hold(2);
        CLR = 1'b0;
        for (int c = cyc; c < 4096; c++) begin
            en_ev[c] = 1'b0;
            ferr_ev[c] = 1'b0;
            perr_ev[c] = 1'b0;
            busy_ev[c] = 1'b0;
        end
        #1;
        check("async_rst_D", D, 8'h00);
        check("async_rst_BUSY", 8'(BUSY), 8'd0);
        hold(3);
        CLR = 1'b1;
        hold(3);
        send_ok(8'h5A);
        hold(3);
        check("D_5A", D, 8'h5A);

`ifdef SER_PARITY_EN
        send(8'h99, 1'b1, 1'b1, 2);
        hold(3);
        check("perr_D", D, 8'h5A);
        send(8'h99, 1'b1, 1'b0, 0);
        hold(3);
        check("par_ok_D", D, 8'h99);
`endif
        hold(5);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
